dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Arbitrates the single SDRAM controller port among three requesters: the camera line-capture write path, the frame readout (read) path, and periodic refresh. It owns the refresh interval timer. It grants whole fixed-length bursts, muxes row/bank toward the DRAM core, and returns a one-cycle acknowledge to the winning requester. It sits between the capture/readout controllers and the DRAM command core.

## Interface
- BURST_LEN, 640: words per read/write burst (one image line).
- REFRESH_INTERVAL, 780: CLK100MHz cycles between refresh demands (7.8 us).
- ROW_W, 13: row address width.
- BANK_W, 2: bank address width.

Ports:
- CLK100MHz  in  1  system clock; all logic on posedge.
- resetN  in  1  asynchronous, active-low reset.
- wrReq  in  1  write request; held until wrAck.
- wrRow  in  ROW_W  write row; sampled at grant.
- wrBank  in  BANK_W  write bank; sampled at grant.
- wrAck  out  1  one-cycle pulse; write burst begins.
- rdReq  in  1  read request; held until rdAck.
- rdRow  in  ROW_W  read row; sampled at grant.
- rdBank  in  BANK_W  read bank; sampled at grant.
- rdAck  out  1  one-cycle pulse; read burst begins.
- memReq  out  1  burst request to DRAM core.
- memWrite  out  1  1 = write burst, 0 = read; valid with memReq.
- memRow  out  ROW_W  registered burst row.
- memBank  out  BANK_W  registered burst bank.
- memAck  in  1  core accepted memReq; one-cycle pulse.
- refreshReq  out  1  refresh command request to core.
- refreshDone  in  1  refresh complete; one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- refreshOverrun  out  1  sticky error flag; cleared only by reset.

## Operation
- States:
  - IDLE.
  - REFRESH.
  - WR_REQ.
  - WR_BURST.
  - RD_REQ.
  - RD_BURST.
- Refresh timer:
  - refTimer counts 0..REFRESH_INTERVAL-1 and wraps.
  - On each wrap, refPending (4 bits) increments, saturating at 8.
  - A wrap while refPending==8 sets refreshOverrun.
- Arming: each requester has an armed flag.
  - The flag sets when its req is seen low.
  - The flag clears on its Ack.
  - A request counts only if req && armed, so a req still high after a burst is not re-granted.
  - Both armed flags are 1 out of reset.
- IDLE priority:
  - refPending!=0 is served first.
  - Otherwise, if the last burst was a write and rd is valid, grant read.
  - Otherwise, if wr is valid, grant write.
  - Otherwise, if rd is valid, grant read.
  - Net effect: refresh > write > read, but reads alternate with writes when both are pending.
- IDLE->WR_REQ: latch wrRow/wrBank into memRow/memBank; memReq=1, memWrite=1. Same for read with memWrite=0.
- X_REQ on memAck:
  - memReq<=0.
  - Pulse the matching Ack for exactly one cycle.
  - beatCnt<=0.
  - Go to X_BURST.
- X_BURST:
  - beatCnt increments each cycle.
  - At beatCnt==BURST_LEN-1, go to IDLE and record lastWasWrite.
  - Requests and refresh expiries arriving during a burst are held pending and never preempt.
- REFRESH: refreshReq=1 until refreshDone. Then refreshReq<=0, refPending decrements, go to IDLE.
- An unknown state encoding recovers to IDLE with all outputs deasserted.

## Timing
- Reset values:
  - wrAck=0, rdAck=0, memReq=0, memWrite=0, memRow=0, memBank=0, refreshReq=0, busy=0, refreshOverrun=0.
  - State=IDLE, refTimer=0, refPending=0.
- Request latency:
  - Valid request at cycle t in IDLE -> memReq=1 at t+1.
  - memAck at cycle u -> Ack=1 and memReq=0 at u+1.
  - Burst occupies u+1..u+BURST_LEN.
  - IDLE at u+BURST_LEN+1.
- Back-to-back: minimum gap between a burst's last beat and the next memReq is 2 cycles (IDLE, then REQ).
- memRow, memBank, memWrite are stable from memReq rise until the next grant.
- refTimer runs in every state. The only effect of reset mid-burst is an immediate return to reset values.
- Simultaneous events:
  - Timer wrap in the same cycle as refreshDone: net refPending is unchanged.
  - wrReq and rdReq rising together in IDLE with lastWasWrite=0: the write wins.

## Test plan
- Single write: wrReq=1, wrRow=5, memAck 3 cycles after memReq -> memWrite=1, memRow=5, one wrAck pulse, busy for 640 cycles, then IDLE.
- Contention: wrReq and rdReq both held, then released after each Ack and reasserted -> grant order W,R,W,R. Each burst is 640 cycles, with a 2-cycle gap.
- Refresh during a burst: timer wraps mid-write -> refreshReq only after the burst ends. It precedes a pending read. refreshDone drops refPending to 0.
- Re-arm: wrReq held high through the whole burst -> no second wrAck until wrReq goes low for ≥1 cycle and high again.
- Overrun: refreshDone held low for 9×780 cycles -> refPending saturates at 8 and refreshOverrun=1, sticky until resetN.
- Reset mid-burst: resetN low at beat 300 -> all outputs are immediately at reset values. After release, the first wrReq is granted normally.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares the single SDRAM controller port between the
// capture write path, the frame readout path and periodic refresh. Grants
// whole fixed-length bursts and owns the refresh interval timer.
module dram_port_arbiter #(
  parameter int unsigned BURST_LEN        = 640,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned ROW_W            = 13,
  parameter int unsigned BANK_W           = 2
) (
  input  logic              CLK100MHz,
  input  logic              resetN,
  input  logic              wrReq,
  input  logic [ROW_W-1:0]  wrRow,
  input  logic [BANK_W-1:0] wrBank,
  output logic              wrAck,
  input  logic              rdReq,
  input  logic [ROW_W-1:0]  rdRow,
  input  logic [BANK_W-1:0] rdBank,
  output logic              rdAck,
  output logic              memReq,
  output logic              memWrite,
  output logic [ROW_W-1:0]  memRow,
  output logic [BANK_W-1:0] memBank,
  input  logic              memAck,
  output logic              refreshReq,
  input  logic              refreshDone,
  output logic              busy,
  output logic              refreshOverrun
);

  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TIMER_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned PEND_W  = 4;
  localparam logic [PEND_W-1:0] REF_MAX = PEND_W'(8);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REFRESH  = 3'd1,
    WR_REQ   = 3'd2,
    WR_BURST = 3'd3,
    RD_REQ   = 3'd4,
    RD_BURST = 3'd5
  } state_t;

  state_t              state, stateNext;
  logic [BEAT_W-1:0]   beatCnt, beatCntNext;
  logic                lastWasWrite, lastWasWriteNext;
  logic                memReqNext, memWriteNext;
  logic [ROW_W-1:0]    memRowNext;
  logic [BANK_W-1:0]   memBankNext;
  logic                wrAckNext, rdAckNext;
  logic                refreshReqNext, busyNext;

  logic [TIMER_W-1:0]  refTimer;
  logic [PEND_W-1:0]   refPending;
  logic                refWrap, refServed;
  logic                wrArmed, rdArmed;
  logic                wrValid, rdValid;

  assign refWrap   = (refTimer == TIMER_W'(REFRESH_INTERVAL - 1));
  assign refServed = (state == REFRESH) && refreshDone && (refPending != '0);
  assign wrValid   = wrReq && wrArmed;
  assign rdValid   = rdReq && rdArmed;

  // Free-running refresh timer, saturating backlog counter and sticky overrun
  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) begin
      refTimer       <= '0;
      refPending     <= '0;
      refreshOverrun <= 1'b0;
    end else begin
      refTimer <= refWrap ? '0 : refTimer + TIMER_W'(1);
      if (refWrap && !refServed) begin
        if (refPending != REF_MAX) refPending <= refPending + PEND_W'(1);
      end else if (!refWrap && refServed) begin
        refPending <= refPending - PEND_W'(1);
      end
      if (refWrap && (refPending == REF_MAX)) refreshOverrun <= 1'b1;
    end
  end

  // Arm flags: a requester must drop its req once before it can win again
  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) begin
      wrArmed <= 1'b1;
      rdArmed <= 1'b1;
    end else begin
      if (wrAckNext)   wrArmed <= 1'b0;
      else if (!wrReq) wrArmed <= 1'b1;
      if (rdAckNext)   rdArmed <= 1'b0;
      else if (!rdReq) rdArmed <= 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      beatCnt      <= '0;
      lastWasWrite <= 1'b0;
      memReq       <= 1'b0;
      memWrite     <= 1'b0;
      memRow       <= '0;
      memBank      <= '0;
      wrAck        <= 1'b0;
      rdAck        <= 1'b0;
      refreshReq   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= stateNext;
      beatCnt      <= beatCntNext;
      lastWasWrite <= lastWasWriteNext;
      memReq       <= memReqNext;
      memWrite     <= memWriteNext;
      memRow       <= memRowNext;
      memBank      <= memBankNext;
      wrAck        <= wrAckNext;
      rdAck        <= rdAckNext;
      refreshReq   <= refreshReqNext;
      busy         <= busyNext;
    end
  end

  // Next-state and next-output decode; refresh > alternating write/read
  always_comb begin
    stateNext        = state;
    beatCntNext      = beatCnt;
    lastWasWriteNext = lastWasWrite;
    memReqNext       = memReq;
    memWriteNext     = memWrite;
    memRowNext       = memRow;
    memBankNext      = memBank;
    wrAckNext        = 1'b0;
    rdAckNext        = 1'b0;
    refreshReqNext   = refreshReq;

    case (state)
      IDLE: begin
        if (refPending != '0) begin
          stateNext      = REFRESH;
          refreshReqNext = 1'b1;
        end else if ((lastWasWrite && rdValid) || (!wrValid && rdValid)) begin
          stateNext    = RD_REQ;
          memReqNext   = 1'b1;
          memWriteNext = 1'b0;
          memRowNext   = rdRow;
          memBankNext  = rdBank;
        end else if (wrValid) begin
          stateNext    = WR_REQ;
          memReqNext   = 1'b1;
          memWriteNext = 1'b1;
          memRowNext   = wrRow;
          memBankNext  = wrBank;
        end
      end
      REFRESH: begin
        if (refreshDone) begin
          refreshReqNext = 1'b0;
          stateNext      = IDLE;
        end
      end
      WR_REQ: begin
        if (memAck) begin
          memReqNext  = 1'b0;
          wrAckNext   = 1'b1;
          beatCntNext = '0;
          stateNext   = WR_BURST;
        end
      end
      RD_REQ: begin
        if (memAck) begin
          memReqNext  = 1'b0;
          rdAckNext   = 1'b1;
          beatCntNext = '0;
          stateNext   = RD_BURST;
        end
      end
      WR_BURST, RD_BURST: begin
        beatCntNext = beatCnt + BEAT_W'(1);
        if (beatCnt == BEAT_W'(BURST_LEN - 1)) begin
          stateNext        = IDLE;
          lastWasWriteNext = (state == WR_BURST);
        end
      end
      default: begin
        stateNext      = IDLE;
        memReqNext     = 1'b0;
        memWriteNext   = 1'b0;
        refreshReqNext = 1'b0;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: behavioural DRAM core and refresh responders,
// grant scoreboard checked on every memReq rise, directed scenarios.
module tb_dram_port_arbiter;

  localparam int unsigned BURST_LEN        = 640;
  localparam int unsigned REFRESH_INTERVAL = 780;
  localparam int unsigned ROW_W            = 13;
  localparam int unsigned BANK_W           = 2;

  logic              CLK100MHz = 1'b0;
  logic              resetN    = 1'b0;
  logic              wrReq     = 1'b0;
  logic [ROW_W-1:0]  wrRow     = '0;
  logic [BANK_W-1:0] wrBank    = '0;
  logic              wrAck;
  logic              rdReq     = 1'b0;
  logic [ROW_W-1:0]  rdRow     = '0;
  logic [BANK_W-1:0] rdBank    = '0;
  logic              rdAck;
  logic              memReq;
  logic              memWrite;
  logic [ROW_W-1:0]  memRow;
  logic [BANK_W-1:0] memBank;
  logic              memAck      = 1'b0;
  logic              refreshReq;
  logic              refreshDone = 1'b0;
  logic              busy;
  logic              refreshOverrun;

  dram_port_arbiter #(
    .BURST_LEN(BURST_LEN), .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .ROW_W(ROW_W), .BANK_W(BANK_W)
  ) dut (
    .CLK100MHz(CLK100MHz), .resetN(resetN),
    .wrReq(wrReq), .wrRow(wrRow), .wrBank(wrBank), .wrAck(wrAck),
    .rdReq(rdReq), .rdRow(rdRow), .rdBank(rdBank), .rdAck(rdAck),
    .memReq(memReq), .memWrite(memWrite), .memRow(memRow), .memBank(memBank),
    .memAck(memAck), .refreshReq(refreshReq), .refreshDone(refreshDone),
    .busy(busy), .refreshOverrun(refreshOverrun)
  );

  always #5 CLK100MHz = ~CLK100MHz;

  typedef struct packed {
    logic              write;
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
  } grant_t;

  grant_t expQ[$];
  int     riseQ[$];
  int     ackQ[$];
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     wrAckCount = 0;
  int     refreshCount = 0;
  int     ackDelay = 3;
  bit     refreshAuto = 1'b1;

  always @(posedge CLK100MHz) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic expectGrant(input logic w, input int r, input int b);
    grant_t g;
    g.write = w;
    g.row   = ROW_W'(r);
    g.bank  = BANK_W'(b);
    expQ.push_back(g);
  endtask

  // DRAM core model: accept each burst request ackDelay cycles after it appears
  initial begin
    forever begin
      @(negedge CLK100MHz);
      if (memReq === 1'b1) begin
        repeat (ackDelay) @(negedge CLK100MHz);
        if (memReq === 1'b1) memAck = 1'b1;
        @(negedge CLK100MHz);
        memAck = 1'b0;
      end
    end
  end

  // Refresh model: complete a requested refresh one cycle later when enabled
  initial begin
    forever begin
      @(negedge CLK100MHz);
      if (refreshReq === 1'b1 && refreshAuto) begin
        @(negedge CLK100MHz);
        refreshDone = 1'b1;
        refreshCount++;
        @(negedge CLK100MHz);
        refreshDone = 1'b0;
      end
    end
  end

  // Monitor: scoreboard on memReq rise, one-cycle ack checks
  logic   memReqPrev = 1'b0, wrAckPrev = 1'b0, rdAckPrev = 1'b0;
  grant_t gExp;
  always @(negedge CLK100MHz) begin
    if (memReq === 1'b1 && memReqPrev !== 1'b1) begin
      riseQ.push_back(cyc);
      if (expQ.size() == 0) begin
        checkVal("unexpectedGrant", 32'd1, 32'd0);
      end else begin
        gExp = expQ.pop_front();
        checkVal("grantMemWrite", 32'(memWrite), 32'(gExp.write));
        checkVal("grantMemRow", 32'(memRow), 32'(gExp.row));
        checkVal("grantMemBank", 32'(memBank), 32'(gExp.bank));
      end
    end
    if (wrAckPrev === 1'b1) checkVal("wrAckWidth", 32'(wrAck), 32'd0);
    if (rdAckPrev === 1'b1) checkVal("rdAckWidth", 32'(rdAck), 32'd0);
    if (wrAck === 1'b1) begin wrAckCount++; ackQ.push_back(cyc); end
    if (rdAck === 1'b1) ackQ.push_back(cyc);
    memReqPrev = memReq;
    wrAckPrev  = wrAck;
    rdAckPrev  = rdAck;
  end

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_wrAck"}, 32'(wrAck), 32'd0);
    checkVal({tag, "_rdAck"}, 32'(rdAck), 32'd0);
    checkVal({tag, "_memReq"}, 32'(memReq), 32'd0);
    checkVal({tag, "_memWrite"}, 32'(memWrite), 32'd0);
    checkVal({tag, "_memRow"}, 32'(memRow), 32'd0);
    checkVal({tag, "_memBank"}, 32'(memBank), 32'd0);
    checkVal({tag, "_refreshReq"}, 32'(refreshReq), 32'd0);
    checkVal({tag, "_busy"}, 32'(busy), 32'd0);
    checkVal({tag, "_refreshOverrun"}, 32'(refreshOverrun), 32'd0);
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    wrReq = 1'b0;
    rdReq = 1'b0;
    refreshAuto = 1'b1;
    repeat (3) @(negedge CLK100MHz);
    resetN = 1'b1;
    riseQ.delete();
    ackQ.delete();
    wrAckCount = 0;
    refreshCount = 0;
  endtask

  task automatic waitWrAck(input string tag);
    int n = 0;
    while (wrAck !== 1'b1 && n < 4000) begin @(negedge CLK100MHz); n++; end
    checkVal(tag, 32'(wrAck), 32'd1);
  endtask

  task automatic waitRdAck(input string tag);
    int n = 0;
    while (rdAck !== 1'b1 && n < 4000) begin @(negedge CLK100MHz); n++; end
    checkVal(tag, 32'(rdAck), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 4000) begin @(negedge CLK100MHz); n++; end
    checkVal(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busyCnt, grants, wrLeft, rdLeft, n;
    bit refDuring, refFirst, readSeen;

    // Reset values
    repeat (3) @(negedge CLK100MHz);
    checkResetValues("reset");
    resetN = 1'b1;

    // Single write, memAck three cycles after memReq
    applyReset();
    expectGrant(1'b1, 5, 1);
    wrRow = 13'd5; wrBank = 2'd1; wrReq = 1'b1;
    @(negedge CLK100MHz);
    checkVal("t1reqLatency", 32'(memReq), 32'd1);
    waitWrAck("t1wrAck");
    checkVal("t1memReqDropped", 32'(memReq), 32'd0);
    wrReq = 1'b0;
    busyCnt = 0;
    while (busy === 1'b1 && busyCnt < 2000) begin busyCnt++; @(negedge CLK100MHz); end
    checkVal("t1burstCycles", 32'(busyCnt), 32'(BURST_LEN));
    checkVal("t1ackLatency", (riseQ.size() > 0 && ackQ.size() > 0) ? 32'(ackQ[0] - riseQ[0]) : 32'd0, 32'd4);
    checkVal("t1wrAckCount", 32'(wrAckCount), 32'd1);

    // Contention: expected grant order W,R,W,R
    applyReset();
    expectGrant(1'b1, 10, 0);
    expectGrant(1'b0, 20, 2);
    expectGrant(1'b1, 11, 0);
    expectGrant(1'b0, 21, 2);
    wrRow = 13'd10; wrBank = 2'd0; rdRow = 13'd20; rdBank = 2'd2;
    wrReq = 1'b1; rdReq = 1'b1;
    wrLeft = 1; rdLeft = 1; grants = 0; n = 0;
    while (grants < 4 && n < 6000) begin
      @(negedge CLK100MHz);
      n++;
      if (wrAck === 1'b1) begin wrReq = 1'b0; grants++; end
      else if (!wrReq && wrLeft > 0) begin wrRow = 13'd11; wrReq = 1'b1; wrLeft--; end
      if (rdAck === 1'b1) begin rdReq = 1'b0; grants++; end
      else if (!rdReq && rdLeft > 0) begin rdRow = 13'd21; rdReq = 1'b1; rdLeft--; end
    end
    checkVal("t2grants", 32'(grants), 32'd4);
    waitIdle("t2idle");
    checkVal("t2gap", (riseQ.size() >= 2 && ackQ.size() >= 1) ? 32'(riseQ[1] - ackQ[0]) : 32'd0,
             32'(BURST_LEN + 1));
    checkVal("t2sbEmpty", 32'(expQ.size()), 32'd0);

    // Refresh expiry during a write burst, read pending behind it
    applyReset();
    repeat (300) @(negedge CLK100MHz);
    expectGrant(1'b1, 7, 2);
    expectGrant(1'b0, 9, 3);
    wrRow = 13'd7; wrBank = 2'd2; wrReq = 1'b1;
    waitWrAck("t3wrAck");
    wrReq = 1'b0;
    rdRow = 13'd9; rdBank = 2'd3; rdReq = 1'b1;
    refDuring = 1'b0; n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (refreshReq === 1'b1) refDuring = 1'b1;
      @(negedge CLK100MHz);
      n++;
    end
    checkVal("t3refreshHeldInBurst", 32'(refDuring), 32'd0);
    refFirst = 1'b0; readSeen = 1'b0; n = 0;
    while (rdAck !== 1'b1 && n < 2000) begin
      if (refreshReq === 1'b1 && !readSeen) refFirst = 1'b1;
      if (memReq === 1'b1) readSeen = 1'b1;
      @(negedge CLK100MHz);
      n++;
    end
    checkVal("t3rdAck", 32'(rdAck), 32'd1);
    checkVal("t3refreshBeforeRead", 32'(refFirst), 32'd1);
    checkVal("t3refreshCount", 32'(refreshCount), 32'd1);
    checkVal("t3rowStable", 32'(memRow), 32'd9);
    rdReq = 1'b0;
    waitIdle("t3idle");

    // Re-arm: held wrReq is not granted twice
    applyReset();
    expectGrant(1'b1, 3, 0);
    wrRow = 13'd3; wrBank = 2'd0; wrReq = 1'b1;
    waitWrAck("t4wrAck1");
    waitIdle("t4idle1");
    repeat (20) @(negedge CLK100MHz);
    checkVal("t4noRegrantReq", 32'(memReq), 32'd0);
    checkVal("t4noRegrantBusy", 32'(busy), 32'd0);
    checkVal("t4ackCount1", 32'(wrAckCount), 32'd1);
    wrReq = 1'b0;
    @(negedge CLK100MHz);
    expectGrant(1'b1, 4, 0);
    wrRow = 13'd4; wrReq = 1'b1;
    waitWrAck("t4wrAck2");
    wrReq = 1'b0;
    @(negedge CLK100MHz);
    checkVal("t4ackCount2", 32'(wrAckCount), 32'd2);
    waitIdle("t4idle2");

    // Overrun: refreshDone withheld for nine intervals
    applyReset();
    refreshAuto = 1'b0;
    repeat (8 * REFRESH_INTERVAL + 5) @(negedge CLK100MHz);
    checkVal("t5noOverrunAtSat", 32'(refreshOverrun), 32'd0);
    checkVal("t5refreshReqHeld", 32'(refreshReq), 32'd1);
    repeat (REFRESH_INTERVAL) @(negedge CLK100MHz);
    checkVal("t5overrunSet", 32'(refreshOverrun), 32'd1);
    refreshAuto = 1'b1;
    repeat (100) @(negedge CLK100MHz);
    checkVal("t5drainCount", 32'(refreshCount), 32'd8);
    checkVal("t5drainedReq", 32'(refreshReq), 32'd0);
    checkVal("t5overrunSticky", 32'(refreshOverrun), 32'd1);
    applyReset();
    @(negedge CLK100MHz);
    checkVal("t5overrunCleared", 32'(refreshOverrun), 32'd0);

    // Reset in the middle of a burst
    expectGrant(1'b1, 6, 1);
    wrRow = 13'd6; wrBank = 2'd1; wrReq = 1'b1;
    waitWrAck("t6wrAck1");
    repeat (300) @(negedge CLK100MHz);
    checkVal("t6busyMidBurst", 32'(busy), 32'd1);
    resetN = 1'b0;
    wrReq = 1'b0;
    #1;
    checkResetValues("t6midBurst");
    repeat (3) @(negedge CLK100MHz);
    resetN = 1'b1;
    expectGrant(1'b1, 8, 0);
    wrRow = 13'd8; wrBank = 2'd0; wrReq = 1'b1;
    @(negedge CLK100MHz);
    checkVal("t6reqAfterReset", 32'(memReq), 32'd1);
    waitWrAck("t6wrAck2");
    wrReq = 1'b0;
    waitIdle("t6idle");
    checkVal("sbEmpty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
